// File: rtl/multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiplier_seq
// Description : Sequential shift-and-add integer multiplier. Computes a
//               WIDTH x WIDTH product with a full 2*WIDTH-bit result in a
//               fixed WIDTH+1 cycles after start is accepted, using one
//               adder and no hardware multiplier. Uses the same start/done
//               handshake as the sequential divider.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous active-low reset
//               start - operation request, sampled only while idle
//               a     - multiplicand, captured on the accepting edge
//               b     - multiplier, captured on the accepting edge
//               busy  - high while an operation is in progress
//               done  - one-cycle completion pulse
//               y     - product, held until the next completion or reset
// Options     : MULTIPLIER_SEQ_SIGNED_EN - when defined, a and b are two's
//               complement and y is the signed product.
// Revision    : 1.0 - initial release
// ============================================================================
module multiplier_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [WIDTH-1:0]     r_mcand,  w_mcand_nxt;
    logic [2*WIDTH-1:0]   r_acc,    w_acc_nxt;
    logic [2*WIDTH-1:0]   r_y,      w_y_nxt;
    logic [CW-1:0]        r_count,  w_count_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_done,   w_done_nxt;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_result;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
    logic                 r_neg, w_neg_nxt;

    // Magnitudes; -2^(W-1) negates to itself, which read as unsigned is the
    // correct magnitude 2^(W-1).
    assign w_a_mag  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_b_mag  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign w_result = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_result = r_acc;
`endif

    // Partial sum keeps the carry so the right shift below loses nothing.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_acc_nxt   = r_acc;
        w_y_nxt     = r_y;
        w_count_nxt = r_count;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
        w_neg_nxt   = r_neg;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mcand_nxt = w_a_mag;
                    w_acc_nxt   = {{WIDTH{1'b0}}, w_b_mag};
                    w_count_nxt = CW'(WIDTH);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
                    w_neg_nxt   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                // Partial sum enters at the top while the consumed
                // multiplier bit falls off the bottom.
                w_acc_nxt   = {w_sum, r_acc[WIDTH-1:1]};
                w_count_nxt = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_y_nxt     = w_result;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_acc   <= w_acc_nxt;
            r_y     <= w_y_nxt;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
            r_neg   <= w_neg_nxt;
`endif
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign y    = r_y;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiplier_seq
// Description : Self-checking directed testbench for multiplier_seq
//               (WIDTH=16). Expected products are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int n_total;
    int n_pass;

    multiplier_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation: latency, busy span, result, done width, hold.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp, input string tag);
        int k;
        int busy_ok;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 16'h5A5A; b = 16'hA5A5;
        k = 0;
        busy_ok = 1;
        while (done !== 1'b1 && k < 40) begin
            if (busy !== 1'b1) busy_ok = 0;
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, 17);
        check({tag, " busy span"}, busy_ok, 1);
        check({tag, " y"}, y, exp);
        check({tag, " busy after"}, busy, 0);
        @(negedge clk);
        check({tag, " done width"}, done, 0);
        check({tag, " y hold"}, y, exp);
    endtask

    initial begin
        int k;
        int ndone;
        int first_k;
        logic [31:0] ycap;
        int dt [3];
        int nd;

        n_total = 0;
        n_pass  = 0;
        rst = 1'b0; start = 1'b0; a = '0; b = '0;

        // 1. reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle y", y, 0);
            check("idle done", done, 0);
            check("idle busy", busy, 0);
        end

        // 2. basic product
        run_op(16'd1234, 16'd567, 32'd699678, "1234x567");
        repeat (3) @(negedge clk);
        check("hold before next op", y, 32'd699678);

        // 3. boundaries
`ifdef MULTIPLIER_SEQ_SIGNED_EN
        run_op(16'hFFFF, 16'hFFFF, 32'h00000001, "ffffxffff");
        run_op(16'hFFFF, 16'h0001, 32'hFFFFFFFF, "ffffx1");
        run_op(16'h8000, 16'h0002, 32'hFFFF0000, "8000x2");
`else
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffffxffff");
        run_op(16'hFFFF, 16'h0001, 32'h0000FFFF, "ffffx1");
        run_op(16'h8000, 16'h0002, 32'h00010000, "8000x2");
`endif
        run_op(16'h0000, 16'hABCD, 32'h0, "0xabcd");
        run_op(16'hABCD, 16'h0000, 32'h0, "abcdx0");

        // 4. start while busy is ignored
        @(negedge clk);
        a = 16'd1234; b = 16'd567; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_k = -1; ycap = '0;
        for (k = 0; k < 30; k++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first_k < 0) begin
                    first_k = k;
                    ycap = y;
                end
            end
            if (k == 3 || k == 10) begin
                a = 16'd99; b = 16'd77; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy-start done count", ndone, 1);
        check("busy-start latency", first_k, 17);
        check("busy-start y", ycap, 32'd699678);

        // 5. start held high: back-to-back
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        nd = 0;
        for (int t = 0; t < 80 && nd < 3; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dt[nd] = t;
                check("b2b y", y, 32'd15);
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b done count", nd, 3);
        if (nd == 3) begin
            check("b2b period 1", dt[1] - dt[0], 18);
            check("b2b period 2", dt[2] - dt[1], 18);
        end
        @(negedge clk);
        check("b2b stopped", busy, 0);

        // 6. reset mid-operation
        @(negedge clk);
        a = 16'd1234; b = 16'd567; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre-reset busy", busy, 1);
        rst = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset y", y, 0);
        check("reset done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("no done after reset", ndone, 0);
        check("idle after reset", busy, 0);
        run_op(16'd7, 16'd9, 32'd63, "7x9");

`ifdef MULTIPLIER_SEQ_SIGNED_EN
        run_op(16'hFFFD, 16'd5, 32'hFFFFFFF1, "-3x5");
        run_op(16'h0003, 16'hFFFB, 32'hFFFFFFF1, "3x-5");
        run_op(16'h8000, 16'h8000, 32'h40000000, "minxmin");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
